// File: rtl/ppl_stage_reg_pkg.sv
// Shared hold codes, bubble control word and buffer state encoding for the
// pipeline stage registers.
package ppl_stage_reg_pkg;

    localparam int HOLD_W = 3;

    localparam logic [HOLD_W-1:0] HOLD_NONE = 3'd0;
    localparam logic [HOLD_W-1:0] HOLD_PC   = 3'd1;
    localparam logic [HOLD_W-1:0] HOLD_IF   = 3'd2;
    localparam logic [HOLD_W-1:0] HOLD_ID   = 3'd3;
    localparam logic [HOLD_W-1:0] HOLD_EX   = 3'd4;
    localparam logic [HOLD_W-1:0] HOLD_MEM  = 3'd5;
    localparam logic [HOLD_W-1:0] HOLD_PPL  = 3'd7;

    // All-zero control word: RegWe=0, mem_ctrl=0, i.e. a harmless bubble.
    localparam logic [11:0] PPL_BUBBLE_CTRL = 12'h000;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } ppl_state_e;

    function automatic logic [1:0] state_occupancy(input ppl_state_e s);
        case (s)
            ST_BUSY: return 2'd1;
            ST_FULL: return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/ppl_stage_reg_skid.sv
// Two-entry main/skid buffer. The main entry drives the outputs; the skid
// entry catches the one item that was in flight when the consumer stalled.
module ppl_skid_buf
    import ppl_stage_reg_pkg::*;
#(
    parameter int W     = 63,
    parameter int CLR_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [W-1:0]     din_i,
    output logic [W-1:0]     dout_o,
    output ppl_state_e       state_o
);

    ppl_state_e   state_q, state_d;
    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_i) begin
            // Only the low CLR_W bits (the control word) are cleared; payload keeps its value.
            state_d              = ST_EMPTY;
            main_d[CLR_W-1:0]    = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (push_i) begin
                        main_d  = din_i;
                        state_d = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (push_i && pop_i) begin
                        main_d = din_i;
                    end else if (push_i) begin
                        skid_d  = din_i;
                        state_d = ST_FULL;
                    end else if (pop_i) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (pop_i) begin
                        main_d  = skid_q;
                        state_d = ST_BUSY;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    assign dout_o  = main_q;
    assign state_o = state_q;

endmodule

// File: rtl/ppl_stage_reg.sv
// Pipeline stage register with valid/ready handshake, skid buffer, hold
// freeze, synchronous flush and a saturating bubble counter.
module ppl_stage_reg
    import ppl_stage_reg_pkg::*;
#(
    parameter int                DW         = 51,
    parameter int                CW         = 12,
    parameter logic [HOLD_W-1:0] HOLD_STAGE = HOLD_EX,
    parameter int                CNTW       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [HOLD_W-1:0] hold_flag,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DW-1:0]     in_data,
    input  logic [CW-1:0]     in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DW-1:0]     out_data,
    output logic [CW-1:0]     out_ctrl,
    output logic [1:0]        occupancy,
    output logic [CNTW-1:0]   bubble_cnt
);

    // Handshake: a transfer happens on a rising clk when valid and ready are
    // both 1 in the preceding cycle; hold masks both sides, flush masks both.
    logic            hold;
    logic            main_valid;
    logic            in_fire;
    logic            out_fire;
    ppl_state_e      state;
    logic [DW+CW-1:0] main_word;
    logic [CNTW-1:0] bub_q, bub_d;

    assign hold       = (hold_flag == HOLD_PPL) || (hold_flag == HOLD_STAGE);
    assign main_valid = (state != ST_EMPTY);

    assign in_ready  = !flush && !hold && (state != ST_FULL);
    assign out_valid = main_valid && !hold;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready && !flush;

    ppl_skid_buf #(
        .W     (DW + CW),
        .CLR_W (CW)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush),
        .push_i  (in_fire),
        .pop_i   (out_fire),
        .din_i   ({in_data, in_ctrl}),
        .dout_o  (main_word),
        .state_o (state)
    );

    assign out_data  = main_word[DW+CW-1:CW];
    assign out_ctrl  = main_valid ? main_word[CW-1:0] : '0;
    assign occupancy = state_occupancy(state);

    always_comb begin
        bub_d = bub_q;
        if (!hold && !out_valid && (bub_q != '1)) begin
            bub_d = bub_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bub_q <= '0;
        end else begin
            bub_q <= bub_d;
        end
    end

    assign bubble_cnt = bub_q;

endmodule

// File: tb/tb_ppl_stage_reg.sv
// Directed bench for ppl_stage_reg: streaming, skid ordering, hold, flush,
// asynchronous reset and bubble counter saturation.
module tb_ppl_stage_reg;
    import ppl_stage_reg_pkg::*;

    localparam int DW = 51;
    localparam int CW = 12;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // main DUT (CNTW=16)
    logic [HOLD_W-1:0] hold_flag;
    logic              flush, in_valid, in_ready, out_valid, out_ready;
    logic [DW-1:0]     in_data, out_data;
    logic [CW-1:0]     in_ctrl, out_ctrl;
    logic [1:0]        occupancy;
    logic [15:0]       bubble_cnt;

    // idle DUT for saturation (CNTW=4)
    logic [HOLD_W-1:0] hold_flag2;
    logic              flush2, in_valid2, in_ready2, out_valid2, out_ready2;
    logic [DW-1:0]     in_data2, out_data2;
    logic [CW-1:0]     in_ctrl2, out_ctrl2;
    logic [1:0]        occupancy2;
    logic [3:0]        bubble_cnt2;

    ppl_stage_reg #(.DW(DW), .CW(CW), .HOLD_STAGE(HOLD_EX), .CNTW(16)) dut (
        .clk(clk), .rst_n(rst_n), .hold_flag(hold_flag), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ctrl(out_ctrl), .occupancy(occupancy), .bubble_cnt(bubble_cnt)
    );

    ppl_stage_reg #(.DW(DW), .CW(CW), .HOLD_STAGE(HOLD_EX), .CNTW(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .hold_flag(hold_flag2), .flush(flush2),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2), .in_ctrl(in_ctrl2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
        .out_ctrl(out_ctrl2), .occupancy(occupancy2), .bubble_cnt(bubble_cnt2)
    );

    // scoreboard counters
    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                         input logic ordy);
        in_valid  = v;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
    endtask

    logic [DW-1:0] vd [8];
    logic [CW-1:0] vc [8];

    initial begin
        vd = '{51'h1_2345_6789, 51'h0_0000_0001, 51'h7_FFFF_FFFF_FFFF, 51'h0_AAAA_5555,
               51'h3_0000_0000_0000, 51'h0_DEAD_BEEF, 51'h0_0000_0000, 51'h5_5555_5555_5555};
        vc = '{12'h801, 12'h002, 12'hFFF, 12'h0A5, 12'h5A0, 12'h123, 12'h7FE, 12'h400};

        rst_n      = 1'b0;
        hold_flag  = HOLD_NONE;
        flush      = 1'b0;
        drive(1'b0, '0, '0, 1'b0);
        hold_flag2 = HOLD_NONE;
        flush2     = 1'b0;
        in_valid2  = 1'b0;
        in_data2   = '0;
        in_ctrl2   = '0;
        out_ready2 = 1'b1;

        // reset values
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_ctrl", out_ctrl, 0);
        check("rst_occ", occupancy, 0);
        check("rst_bub", bubble_cnt, 0);
        check("rst_in_ready", in_ready, 1);
        tick();
        rst_n = 1'b1;

        // streaming at full throughput
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, vd[i], vc[i], 1'b1);
            #1;
            check("stream_in_ready", in_ready, 1);
            tick();
            check("stream_data", out_data, vd[i]);
            check("stream_ctrl", out_ctrl, vc[i]);
            check("stream_valid", out_valid, 1);
            check("stream_occ", occupancy, 1);
        end
        check("stream_bub", bubble_cnt, 1);
        drive(1'b0, '0, '0, 1'b1);
        tick();
        check("drain_occ", occupancy, 0);
        check("drain_valid", out_valid, 0);
        check("drain_ctrl", out_ctrl, 0);

        // skid: A then B, consumer stalls after A is loaded
        drive(1'b1, 51'hA, 12'h0AA, 1'b1);
        tick();
        drive(1'b1, 51'hB, 12'h0BB, 1'b0);
        #1;
        check("skid_a_out", out_data, 51'hA);
        check("skid_a_ready", in_ready, 1);
        tick();
        drive(1'b1, 51'hC, 12'h0CC, 1'b0);
        #1;
        check("skid_full_occ", occupancy, 2);
        check("skid_full_ready", in_ready, 0);
        check("skid_full_head", out_data, 51'hA);
        tick();
        check("skid_full_hold_occ", occupancy, 2);
        drive(1'b0, '0, '0, 1'b1);
        #1;
        check("skid_pop_a", out_data, 51'hA);
        check("skid_pop_a_ctrl", out_ctrl, 12'h0AA);
        tick();
        check("skid_pop_b", out_data, 51'hB);
        check("skid_pop_b_ctrl", out_ctrl, 12'h0BB);
        check("skid_pop_b_occ", occupancy, 1);
        tick();
        check("skid_empty_occ", occupancy, 0);
        check("skid_empty_valid", out_valid, 0);
        check("skid_bub", bubble_cnt, 2);

        // hold code decoding
        hold_flag = HOLD_ID;
        #1;
        check("hold_other_ready", in_ready, 1);
        hold_flag = HOLD_PPL;
        #1;
        check("hold_ppl_ready", in_ready, 0);
        hold_flag = HOLD_NONE;

        // hold in BUSY for 3 cycles
        drive(1'b1, 51'hD, 12'h0DD, 1'b0);
        tick();
        check("hold_pre_bub", bubble_cnt, 3);
        hold_flag = HOLD_EX;
        drive(1'b1, 51'hE, 12'h0EE, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("hold_valid", out_valid, 0);
            check("hold_ready", in_ready, 0);
            tick();
            check("hold_data", out_data, 51'hD);
            check("hold_occ", occupancy, 1);
            check("hold_bub", bubble_cnt, 3);
        end
        hold_flag = HOLD_NONE;
        #1;
        check("resume_valid", out_valid, 1);
        check("resume_data", out_data, 51'hD);
        tick();
        check("resume_next", out_data, 51'hE);
        check("resume_next_ctrl", out_ctrl, 12'h0EE);
        drive(1'b0, '0, '0, 1'b1);
        tick();
        check("resume_occ", occupancy, 0);
        check("resume_bub", bubble_cnt, 3);

        // flush in FULL under Hold_PPL
        drive(1'b1, 51'hF, 12'h0FF, 1'b0);
        tick();
        drive(1'b1, 51'h10, 12'h010, 1'b0);
        tick();
        check("flush_pre_occ", occupancy, 2);
        flush     = 1'b1;
        hold_flag = HOLD_PPL;
        drive(1'b1, 51'h11, 12'h011, 1'b1);
        #1;
        check("flush_in_ready", in_ready, 0);
        check("flush_out_valid", out_valid, 0);
        tick();
        flush     = 1'b0;
        hold_flag = HOLD_NONE;
        drive(1'b0, '0, '0, 1'b1);
        #1;
        check("flush_occ", occupancy, 0);
        check("flush_ctrl", out_ctrl, 0);
        check("flush_valid", out_valid, 0);
        check("flush_bub", bubble_cnt, 4);
        tick();
        check("flush_dropped", out_valid, 0);
        check("flush_bub_next", bubble_cnt, 5);

        // asynchronous reset in FULL
        drive(1'b1, 51'h21, 12'h021, 1'b0);
        tick();
        drive(1'b1, 51'h22, 12'h022, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b0);
        #1;
        check("arst_pre_occ", occupancy, 2);
        check("arst_pre_bub", bubble_cnt, 6);
        rst_n = 1'b0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_data", out_data, 0);
        check("arst_ctrl", out_ctrl, 0);
        check("arst_occ", occupancy, 0);
        check("arst_bub", bubble_cnt, 0);
        tick();
        rst_n = 1'b1;

        // idle: CNTW=4 counter saturates at 15
        repeat (14) tick();
        check("sat_bub_14", bubble_cnt2, 14);
        check("main_bub_14", bubble_cnt, 14);
        repeat (6) tick();
        check("sat_bub_15", bubble_cnt2, 15);
        check("main_bub_20", bubble_cnt, 20);
        check("sat_occ", occupancy2, 0);
        check("sat_valid", out_valid2, 0);
        check("sat_ready", in_ready2, 1);
        check("sat_data", out_data2, 0);
        check("sat_ctrl", out_ctrl2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ppl_stage_reg.md
# ppl_stage_reg

Parametrised pipeline stage register, the successor to the fixed ID/EX latch. It carries a configurable data payload and control word between two CPU pipeline stages. On top of the existing hold-code freeze it adds a valid/ready handshake, a 2-entry skid buffer, synchronous flush with bubble insertion, and a bubble performance counter. One instance per stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).

## Interface
- DW, 51: payload width; packs rd, RD, RS, IMM for the ID/EX instance.
- CW, 12: control-word width; an all-zero control word is a legal bubble (RegWe=0, mem_ctrl=0).
- HOLD_STAGE, `Hold_EX: hold code that freezes this stage. `Hold_PPL always freezes it.
- CNTW, 16: bubble counter width.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- hold_flag  in  `HOLDBUS  global hold code from the hazard controller.
- flush  in  1  synchronous kill of all contents.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept; combinational: ~flush & ~hold & (state != FULL).
- in_data  in  DW  upstream payload.
- in_ctrl  in  CW  upstream control word.
- out_valid  out  1  main-entry valid & ~hold.
- out_ready  in  1  downstream accepts.
- out_data  out  DW  main-entry payload.
- out_ctrl  out  CW  main-entry control word; forced to 0 whenever the main entry is invalid.
- occupancy  out  2  number of entries held (0..2).
- bubble_cnt  out  CNTW  saturating count of cycles with out_valid=0 and no hold active.

## Operation
- hold = (hold_flag == `Hold_PPL) | (hold_flag == HOLD_STAGE).
- in_fire = in_valid & in_ready.
- out_fire = out_valid & out_ready.
- Storage has two entries: the main register, which drives the outputs, and the skid register.
- The state machine is derived from the valid bits:
  - EMPTY: no entries.
  - BUSY: main entry only.
  - FULL: main and skid entries.
- Transitions (flush=0, hold=0):
  - EMPTY, in_fire -> BUSY; input is loaded into main.
  - BUSY, in_fire & ~out_fire -> FULL; input is loaded into skid.
  - BUSY, in_fire & out_fire -> BUSY; input is loaded into main.
  - BUSY, ~in_fire & out_fire -> EMPTY.
  - FULL, out_fire -> BUSY; skid moves to main. in_ready is 0 in FULL.
- Ordering is strict FIFO; entries never reorder.
- Hold:
  - No in_fire and no out_fire; all registers keep their value.
  - out_data/out_ctrl stay stable; out_valid is masked to 0.
- Flush:
  - Highest priority, including over hold.
  - Next state is EMPTY, both valid bits clear, main ctrl is cleared to 0.
  - Input presented in the flush cycle is dropped (in_ready=0).
  - Payload data registers are don't-care but not toggled.
- bubble_cnt:
  - Increments when ~hold & ~out_valid.
  - Saturates at 2^CNTW-1.
  - Cleared only by reset; flush does not clear it.

## Timing
- Reset values:
  - State EMPTY; out_valid 0; out_data 0; out_ctrl 0; occupancy 0; bubble_cnt 0.
  - in_ready=1 unless hold or flush is asserted.
- Latency: an entry accepted at edge N appears on out_* after edge N with out_valid=1. One cycle of latency, full throughput of 1 entry per cycle when out_ready=1.
- The skid entry absorbs exactly one in-flight item when out_ready drops. in_ready falls the cycle after FULL is reached.
- Simultaneous cases:
  - in_fire & out_fire in FULL cannot occur.
  - flush & hold: flush wins.
  - flush & out_ready: no out_fire.
- Reset asserted mid-transfer clears everything immediately (asynchronously). Deassertion is synchronised externally.

## Structure
- `HOLDBUS, `Hold_PPL and the per-stage `Hold_* codes remain in para.v.
- Add `PPL_BUBBLE_CTRL (all-zero control) to para.v.
- Implement as a single module. The skid/main pair is a natural sub-module, ppl_skid_buf (width DW+CW), with the hold/flush/counter logic wrapped around it.
- ID_EX is replaced by an instance with DW=51, CW=12, HOLD_STAGE=`Hold_EX.

## Test plan
- Reset, then stream 8 entries with out_ready=1 and no hold:
  - out_data follows in_data one cycle later.
  - occupancy is 1 throughout.
  - bubble_cnt=1 (first cycle only).
- Send entries 0xA, 0xB back-to-back, drop out_ready after 0xA is loaded:
  - state reaches FULL, in_ready=0.
  - On out_ready=1, 0xA then 0xB emerge in order.
- hold_flag=`Hold_EX for 3 cycles in BUSY with in_valid=1:
  - out_valid=0, in_ready=0, out_data unchanged.
  - bubble_cnt unchanged.
  - Resumes with no loss.
- flush in FULL with hold_flag=`Hold_PPL:
  - Next cycle occupancy=0, out_ctrl=0, out_valid=0.
  - The input word presented in the flush cycle never appears.
- CNTW=4, idle for 20 cycles: bubble_cnt saturates at 15.
- Assert rst_n=0 asynchronously in FULL: all outputs are 0 before the next clk edge.
